mem_req_arb: RTL and testbench

- Shares the MMU's single memory request channel (mem_req_o / mem_resp_i) between N requesters, e.g. the page-table walker and the LLC writeback/fill path.
- Arbitrates requests round-robin through a one-entry registered output slot.
- Tags each outgoing idx with the source number and routes responses back by that tag.
- Enforces a per-source outstanding-request limit.

---
 rtl/mem_req_arb_if.sv | 70 +++++++
 rtl/mem_req_arb.sv | 147 ++++++++++++++
 tb/tb_mem_req_arb.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_req_arb_if.sv
// Bundled request/response channels between N requesters, the arbiter and the memory port.
// The arbiter connects through the slave modport; the environment uses master.
interface mem_req_arb_if #(
  parameter int unsigned N      = 2,
  parameter int unsigned IDX_W  = 4,
  parameter int unsigned SW     = (N > 1) ? $clog2(N) : 1,
  parameter int unsigned MCN_W  = 28,
  parameter int unsigned PCN_W  = 28,
  parameter int unsigned DATA_W = 512
);
  logic [N-1:0]        req_i_valid;
  logic [N-1:0]        req_i_ready;
  logic [N*IDX_W-1:0]  req_i_bits_idx;
  logic [N-1:0]        req_i_bits_rnw;
  logic [N*MCN_W-1:0]  req_i_bits_mcn;
  logic [N*PCN_W-1:0]  req_i_bits_pcn;
  logic [N*DATA_W-1:0] req_i_bits_data;

  logic                mem_req_o_valid;
  logic                mem_req_o_ready;
  logic [SW+IDX_W-1:0] mem_req_o_bits_idx;
  logic                mem_req_o_bits_rnw;
  logic [MCN_W-1:0]    mem_req_o_bits_mcn;
  logic [PCN_W-1:0]    mem_req_o_bits_pcn;
  logic [DATA_W-1:0]   mem_req_o_bits_data;

  logic                mem_resp_i_valid;
  logic                mem_resp_i_ready;
  logic [SW+IDX_W-1:0] mem_resp_i_bits_idx;
  logic                mem_resp_i_bits_err;
  logic                mem_resp_i_bits_rnw;
  logic [DATA_W-1:0]   mem_resp_i_bits_data;

  logic [N-1:0]        resp_o_valid;
  logic [N-1:0]        resp_o_ready;
  logic [IDX_W-1:0]    resp_o_bits_idx;
  logic                resp_o_bits_err;
  logic                resp_o_bits_rnw;
  logic [DATA_W-1:0]   resp_o_bits_data;

  logic                tag_err_o;

  modport slave (
    input  req_i_valid, req_i_bits_idx, req_i_bits_rnw, req_i_bits_mcn, req_i_bits_pcn, req_i_bits_data,
    output req_i_ready,
    output mem_req_o_valid, mem_req_o_bits_idx, mem_req_o_bits_rnw, mem_req_o_bits_mcn,
           mem_req_o_bits_pcn, mem_req_o_bits_data,
    input  mem_req_o_ready,
    input  mem_resp_i_valid, mem_resp_i_bits_idx, mem_resp_i_bits_err, mem_resp_i_bits_rnw,
           mem_resp_i_bits_data,
    output mem_resp_i_ready,
    output resp_o_valid, resp_o_bits_idx, resp_o_bits_err, resp_o_bits_rnw, resp_o_bits_data,
    input  resp_o_ready,
    output tag_err_o
  );

  modport master (
    output req_i_valid, req_i_bits_idx, req_i_bits_rnw, req_i_bits_mcn, req_i_bits_pcn, req_i_bits_data,
    input  req_i_ready,
    input  mem_req_o_valid, mem_req_o_bits_idx, mem_req_o_bits_rnw, mem_req_o_bits_mcn,
           mem_req_o_bits_pcn, mem_req_o_bits_data,
    output mem_req_o_ready,
    output mem_resp_i_valid, mem_resp_i_bits_idx, mem_resp_i_bits_err, mem_resp_i_bits_rnw,
           mem_resp_i_bits_data,
    input  mem_resp_i_ready,
    input  resp_o_valid, resp_o_bits_idx, resp_o_bits_err, resp_o_bits_rnw, resp_o_bits_data,
    output resp_o_ready,
    input  tag_err_o
  );
endinterface

// File: rtl/mem_req_arb.sv
// Round-robin arbiter sharing one memory request channel between N requesters,
// with source-tagged response routing and per-source outstanding limits.
module mem_req_arb #(
  parameter int unsigned N       = 2,
  parameter int unsigned IDX_W   = 4,
  parameter int unsigned SW      = (N > 1) ? $clog2(N) : 1,
  parameter int unsigned MCN_W   = 28,
  parameter int unsigned PCN_W   = 28,
  parameter int unsigned DATA_W  = 512,
  parameter int unsigned MAX_OUT = 8
) (
  input logic          clock,
  input logic          reset,
  mem_req_arb_if.slave bus
);
  localparam int unsigned CW = $clog2(MAX_OUT + 1);
  localparam int unsigned TW = SW + IDX_W;

  logic              slot_valid;
  logic [TW-1:0]     slot_idx;
  logic              slot_rnw;
  logic [MCN_W-1:0]  slot_mcn;
  logic [PCN_W-1:0]  slot_pcn;
  logic [DATA_W-1:0] slot_data;
  logic [SW-1:0]     ptr;
  logic [CW-1:0]     cnt [N];

  logic              free;
  logic              accept;
  logic [N-1:0]      elig;
  logic [N-1:0]      grant;
  int unsigned       gsel;
  int unsigned       j;

  logic [SW-1:0]     rs;
  int unsigned       rs_int;
  logic [CW-1:0]     rs_cnt;
  logic              rs_rdy;
  logic              bad;
  logic              resp_hs;
  logic [N-1:0]      inc;
  logic [N-1:0]      dec;

  assign free = !slot_valid || bus.mem_req_o_ready;

  always_comb begin
    elig = '0;
    for (int unsigned i = 0; i < N; i++)
      elig[i] = bus.req_i_valid[i] && (cnt[i] < CW'(MAX_OUT));
  end

  // First eligible source at or after ptr wins; grant is suppressed while the slot is busy.
  always_comb begin
    grant  = '0;
    accept = 1'b0;
    gsel   = 0;
    j      = 0;
    if (reset && free) begin
      for (int unsigned k = 0; k < N; k++) begin
        j = (32'(ptr) + k) % N;
        if (!accept && elig[j]) begin
          grant[j] = 1'b1;
          gsel     = j;
          accept   = 1'b1;
        end
      end
    end
  end

  assign bus.req_i_ready = grant;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      slot_valid <= 1'b0;
      slot_idx   <= '0;
      slot_rnw   <= 1'b0;
      slot_mcn   <= '0;
      slot_pcn   <= '0;
      slot_data  <= '0;
      ptr        <= '0;
    end else if (free) begin
      slot_valid <= accept;
      if (accept) begin
        slot_idx  <= {SW'(gsel), bus.req_i_bits_idx[gsel*IDX_W +: IDX_W]};
        slot_rnw  <= bus.req_i_bits_rnw[gsel];
        slot_mcn  <= bus.req_i_bits_mcn[gsel*MCN_W +: MCN_W];
        slot_pcn  <= bus.req_i_bits_pcn[gsel*PCN_W +: PCN_W];
        slot_data <= bus.req_i_bits_data[gsel*DATA_W +: DATA_W];
        ptr       <= SW'((gsel + 1) % N);
      end
    end
  end

  assign bus.mem_req_o_valid     = slot_valid;
  assign bus.mem_req_o_bits_idx  = slot_idx;
  assign bus.mem_req_o_bits_rnw  = slot_rnw;
  assign bus.mem_req_o_bits_mcn  = slot_mcn;
  assign bus.mem_req_o_bits_pcn  = slot_pcn;
  assign bus.mem_req_o_bits_data = slot_data;

  assign rs = bus.mem_resp_i_bits_idx[TW-1:IDX_W];

  // Tags outside 0..N-1 or with nothing outstanding are swallowed and flagged.
  always_comb begin
    rs_int = 32'(rs);
    rs_cnt = '0;
    rs_rdy = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (rs_int == i) begin
        rs_cnt = cnt[i];
        rs_rdy = bus.resp_o_ready[i];
      end
    end
    bad      = (rs_int >= N) || (rs_cnt == '0);
    resp_hs  = bus.mem_resp_i_valid && !bad && rs_rdy;
    bus.resp_o_valid = '0;
    for (int unsigned i = 0; i < N; i++)
      bus.resp_o_valid[i] = reset && bus.mem_resp_i_valid && !bad && (rs_int == i);
    bus.mem_resp_i_ready = bad || rs_rdy;
    bus.tag_err_o        = reset && bus.mem_resp_i_valid && bad;
  end

  assign bus.resp_o_bits_idx  = bus.mem_resp_i_bits_idx[IDX_W-1:0];
  assign bus.resp_o_bits_err  = bus.mem_resp_i_bits_err;
  assign bus.resp_o_bits_rnw  = bus.mem_resp_i_bits_rnw;
  assign bus.resp_o_bits_data = bus.mem_resp_i_bits_data;

  always_comb begin
    inc = '0;
    dec = '0;
    for (int unsigned i = 0; i < N; i++) begin
      inc[i] = accept && (gsel == i);
      dec[i] = resp_hs && (rs_int == i);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < N; i++) cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < N; i++) begin
        if (inc[i] && !dec[i])      cnt[i] <= cnt[i] + CW'(1);
        else if (dec[i] && !inc[i]) cnt[i] <= cnt[i] - CW'(1);
      end
    end
  end
endmodule

// File: tb/tb_mem_req_arb.sv
// Directed bench for mem_req_arb: a transaction-level model checked every cycle,
// plus literal expectations for grant order, stalls, limits, routing, bad tags and reset.
module tb_mem_req_arb;
  localparam int N = 2;
  localparam int IDX_W = 4;
  localparam int DW = 32;
  localparam int MAX_OUT = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mem_req_arb_if #(.N(2), .IDX_W(4), .SW(1), .MCN_W(28), .PCN_W(28), .DATA_W(DW)) bus ();
  mem_req_arb_if #(.N(3), .IDX_W(4), .SW(2), .MCN_W(28), .PCN_W(28), .DATA_W(DW)) bus3 ();

  mem_req_arb #(.N(2), .IDX_W(4), .SW(1), .MCN_W(28), .PCN_W(28), .DATA_W(DW), .MAX_OUT(MAX_OUT)) dut (
    .clock(clk), .reset(rst_n), .bus(bus));
  mem_req_arb #(.N(3), .IDX_W(4), .SW(2), .MCN_W(28), .PCN_W(28), .DATA_W(DW), .MAX_OUT(4)) dut3 (
    .clock(clk), .reset(rst_n), .bus(bus3));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", nm, $time, act, exp);
    end
  endtask

  function automatic logic [27:0] f_mcn(int s, int seed); return 28'(seed * 7 + s * 1000); endfunction
  function automatic logic [27:0] f_pcn(int s, int seed); return 28'(seed * 13 + s + 1); endfunction
  function automatic logic [31:0] f_data(int s, int seed); return 32'(seed * 65537 + s * 32'h0A000000); endfunction

  task automatic load(input int s, input int seed);
    bus.req_i_bits_idx[s*IDX_W +: IDX_W] = 4'(seed);
    bus.req_i_bits_rnw[s]                = 1'(seed & 1);
    bus.req_i_bits_mcn[s*28 +: 28]       = f_mcn(s, seed);
    bus.req_i_bits_pcn[s*28 +: 28]       = f_pcn(s, seed);
    bus.req_i_bits_data[s*DW +: DW]      = f_data(s, seed);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic zero_inputs;
    bus.req_i_valid = '0; bus.req_i_bits_idx = '0; bus.req_i_bits_rnw = '0;
    bus.req_i_bits_mcn = '0; bus.req_i_bits_pcn = '0; bus.req_i_bits_data = '0;
    bus.mem_req_o_ready = 1'b0; bus.mem_resp_i_valid = 1'b0; bus.mem_resp_i_bits_idx = '0;
    bus.mem_resp_i_bits_err = 1'b0; bus.mem_resp_i_bits_rnw = 1'b0; bus.mem_resp_i_bits_data = '0;
    bus.resp_o_ready = '0;
    bus3.req_i_valid = '0; bus3.req_i_bits_idx = '0; bus3.req_i_bits_rnw = '0;
    bus3.req_i_bits_mcn = '0; bus3.req_i_bits_pcn = '0; bus3.req_i_bits_data = '0;
    bus3.mem_req_o_ready = 1'b0; bus3.mem_resp_i_valid = 1'b0; bus3.mem_resp_i_bits_idx = '0;
    bus3.mem_resp_i_bits_err = 1'b0; bus3.mem_resp_i_bits_rnw = 1'b0; bus3.mem_resp_i_bits_data = '0;
    bus3.resp_o_ready = '0;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    zero_inputs();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Transaction-level model: the slot as a pending record, counts as plain integers.
  int          m_cnt [N];
  int          m_ptr;
  bit          m_valid;
  logic [4:0]  m_idx;
  logic        m_rnw;
  logic [27:0] m_mcn, m_pcn;
  logic [31:0] m_data;

  always @(negedge clk) begin
    int g, s;
    bit free, bad;
    logic [N-1:0] e_ready, e_rv;
    logic e_mri;
    if (!rst_n) begin
      chk("rst_req_ready", 64'(bus.req_i_ready), 64'(0));
      chk("rst_mem_valid", 64'(bus.mem_req_o_valid), 64'(0));
      chk("rst_resp_valid", 64'(bus.resp_o_valid), 64'(0));
      chk("rst_tag_err", 64'(bus.tag_err_o), 64'(0));
      m_valid = 1'b0; m_ptr = 0;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
    end else begin
      free = !m_valid || bus.mem_req_o_ready;
      g = -1;
      if (free)
        for (int k = 0; k < N; k++)
          if (g < 0 && bus.req_i_valid[(m_ptr + k) % N] && m_cnt[(m_ptr + k) % N] < MAX_OUT)
            g = (m_ptr + k) % N;
      e_ready = (g >= 0) ? N'(1 << g) : '0;
      s = int'(bus.mem_resp_i_bits_idx >> IDX_W);
      bad = (s >= N) || (m_cnt[s] == 0);
      e_rv = (bus.mem_resp_i_valid && !bad) ? N'(1 << s) : '0;
      e_mri = bad ? 1'b1 : bus.resp_o_ready[s];
      chk("m_req_ready", 64'(bus.req_i_ready), 64'(e_ready));
      chk("m_mem_valid", 64'(bus.mem_req_o_valid), 64'(m_valid));
      if (m_valid) begin
        chk("m_mem_idx", 64'(bus.mem_req_o_bits_idx), 64'(m_idx));
        chk("m_mem_rnw", 64'(bus.mem_req_o_bits_rnw), 64'(m_rnw));
        chk("m_mem_mcn", 64'(bus.mem_req_o_bits_mcn), 64'(m_mcn));
        chk("m_mem_pcn", 64'(bus.mem_req_o_bits_pcn), 64'(m_pcn));
        chk("m_mem_data", 64'(bus.mem_req_o_bits_data), 64'(m_data));
      end
      chk("m_resp_valid", 64'(bus.resp_o_valid), 64'(e_rv));
      chk("m_resp_ready", 64'(bus.mem_resp_i_ready), 64'(e_mri));
      chk("m_tag_err", 64'(bus.tag_err_o), 64'(bus.mem_resp_i_valid && bad));
      if (e_rv != '0) chk("m_resp_idx", 64'(bus.resp_o_bits_idx), 64'(bus.mem_resp_i_bits_idx[3:0]));
      if (free) begin
        m_valid = (g >= 0);
        if (g >= 0) begin
          m_idx  = {1'(g), bus.req_i_bits_idx[g*IDX_W +: IDX_W]};
          m_rnw  = bus.req_i_bits_rnw[g];
          m_mcn  = bus.req_i_bits_mcn[g*28 +: 28];
          m_pcn  = bus.req_i_bits_pcn[g*28 +: 28];
          m_data = bus.req_i_bits_data[g*DW +: DW];
          m_ptr  = (g + 1) % N;
          m_cnt[g]++;
        end
      end
      if (bus.mem_resp_i_valid && !bad && bus.resp_o_ready[s]) m_cnt[s]--;
    end
  end

  initial begin
    zero_inputs();
    tick();
    tick();
    rst_n = 1'b1;

    // Alternating grants with both sources requesting and memory always ready
    bus.req_i_valid = 2'b11;
    bus.mem_req_o_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      load(0, c);
      load(1, c);
      @(negedge clk);
      chk("t1_ready", 64'(bus.req_i_ready), (c % 2 == 1) ? 64'h2 : 64'h1);
      chk("t1_valid", 64'(bus.mem_req_o_valid), (c > 0) ? 64'h1 : 64'h0);
      if (c > 0) chk("t1_tag", 64'(bus.mem_req_o_bits_idx[4]), (c % 2 == 1) ? 64'h0 : 64'h1);
      tick();
    end
    do_reset();

    // Stall: slot holds while memory is not ready
    bus.req_i_valid = 2'b01;
    load(0, 20);
    @(negedge clk);
    chk("t2_first_ready", 64'(bus.req_i_ready), 64'h1);
    tick();
    for (int k = 0; k < 5; k++) begin
      load(0, 21 + k);
      @(negedge clk);
      chk("t2_valid", 64'(bus.mem_req_o_valid), 64'h1);
      chk("t2_idx", 64'(bus.mem_req_o_bits_idx), 64'h04);
      chk("t2_data", 64'(bus.mem_req_o_bits_data), 64'(f_data(0, 20)));
      chk("t2_mcn", 64'(bus.mem_req_o_bits_mcn), 64'(f_mcn(0, 20)));
      chk("t2_ready_held", 64'(bus.req_i_ready), 64'h0);
      tick();
    end
    bus.mem_req_o_ready = 1'b1;
    @(negedge clk);
    chk("t2_ready_release", 64'(bus.req_i_ready), 64'h1);
    tick();
    do_reset();

    // Outstanding limit on source 1
    bus.mem_req_o_ready = 1'b1;
    bus.req_i_valid = 2'b10;
    for (int c = 0; c < 8; c++) begin
      load(1, 30 + c);
      @(negedge clk);
      chk("t3_fill_ready", 64'(bus.req_i_ready), 64'h2);
      tick();
    end
    bus.req_i_valid = 2'b11;
    load(0, 50);
    load(1, 38);
    @(negedge clk);
    chk("t3_limit_src0", 64'(bus.req_i_ready), 64'h1);
    tick();
    bus.req_i_valid = 2'b10;
    bus.mem_resp_i_valid = 1'b1;
    bus.mem_resp_i_bits_idx = 5'h13;
    bus.resp_o_ready = 2'b10;
    @(negedge clk);
    chk("t3_limit_held", 64'(bus.req_i_ready), 64'h0);
    chk("t3_resp_valid", 64'(bus.resp_o_valid), 64'h2);
    chk("t3_resp_ready", 64'(bus.mem_resp_i_ready), 64'h1);
    tick();
    bus.mem_resp_i_valid = 1'b0;
    @(negedge clk);
    chk("t3_ninth_ready", 64'(bus.req_i_ready), 64'h2);
    tick();

    // Response routing with backpressure; count drops only on handshake
    bus.mem_resp_i_valid = 1'b1;
    bus.mem_resp_i_bits_idx = 5'h1A;
    bus.mem_resp_i_bits_data = 32'hCAFE_0001;
    bus.resp_o_ready = 2'b00;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("t4_resp_valid", 64'(bus.resp_o_valid), 64'h2);
      chk("t4_resp_idx", 64'(bus.resp_o_bits_idx), 64'hA);
      chk("t4_resp_data", 64'(bus.resp_o_bits_data), 64'hCAFE_0001);
      chk("t4_mri_low", 64'(bus.mem_resp_i_ready), 64'h0);
      chk("t4_req_held", 64'(bus.req_i_ready), 64'h0);
      tick();
    end
    bus.resp_o_ready = 2'b10;
    @(negedge clk);
    chk("t4_mri_high", 64'(bus.mem_resp_i_ready), 64'h1);
    chk("t4_req_still_held", 64'(bus.req_i_ready), 64'h0);
    tick();
    bus.mem_resp_i_valid = 1'b0;
    @(negedge clk);
    chk("t4_req_after_hs", 64'(bus.req_i_ready), 64'h2);
    tick();
    do_reset();

    // Underflow on N=2 and out-of-range tag on N=3
    bus.mem_resp_i_valid = 1'b1;
    bus.mem_resp_i_bits_idx = 5'h05;
    bus.resp_o_ready = 2'b11;
    bus3.mem_resp_i_valid = 1'b1;
    bus3.mem_resp_i_bits_idx = 6'h35;
    bus3.resp_o_ready = 3'b111;
    @(negedge clk);
    chk("t5_tag_err", 64'(bus.tag_err_o), 64'h1);
    chk("t5_mri", 64'(bus.mem_resp_i_ready), 64'h1);
    chk("t5_no_resp", 64'(bus.resp_o_valid), 64'h0);
    chk("t5_n3_tag_err", 64'(bus3.tag_err_o), 64'h1);
    chk("t5_n3_mri", 64'(bus3.mem_resp_i_ready), 64'h1);
    chk("t5_n3_no_resp", 64'(bus3.resp_o_valid), 64'h0);
    tick();
    bus.mem_resp_i_valid = 1'b0;
    bus3.mem_resp_i_valid = 1'b0;
    @(negedge clk);
    chk("t5_tag_err_clear", 64'(bus.tag_err_o), 64'h0);
    chk("t5_n3_tag_err_clear", 64'(bus3.tag_err_o), 64'h0);
    tick();
    do_reset();

    // Asynchronous reset with a full slot and three outstanding
    bus.mem_req_o_ready = 1'b1;
    bus.req_i_valid = 2'b01;
    for (int c = 0; c < 3; c++) begin
      load(0, 40 + c);
      tick();
    end
    bus.mem_req_o_ready = 1'b0;
    bus.req_i_valid = 2'b00;
    @(negedge clk);
    chk("t6_slot_full", 64'(bus.mem_req_o_valid), 64'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_valid", 64'(bus.mem_req_o_valid), 64'h0);
    chk("t6_async_ready", 64'(bus.req_i_ready), 64'h0);
    tick();
    tick();
    rst_n = 1'b1;
    bus.req_i_valid = 2'b11;
    bus.mem_req_o_ready = 1'b1;
    load(0, 60);
    load(1, 61);
    @(negedge clk);
    chk("t6_first_grant", 64'(bus.req_i_ready), 64'h1);
    tick();
    bus.req_i_valid = 2'b00;
    bus.mem_resp_i_valid = 1'b1;
    bus.mem_resp_i_bits_idx = 5'h07;
    bus.resp_o_ready = 2'b01;
    @(negedge clk);
    chk("t6_resp_ok", 64'(bus.resp_o_valid), 64'h1);
    tick();
    @(negedge clk);
    chk("t6_cnt_cleared", 64'(bus.tag_err_o), 64'h1);
    tick();
    bus.mem_resp_i_valid = 1'b0;
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
